// File: rtl/ws_seq_pkg.sv
// Shared definitions for the weight-stationary instruction sequencer:
// bit positions of every field in the 38-bit core instruction word,
// the idle word, the sequencer state encoding and the named control bundle.
package ws_seq_pkg;

    localparam int INST_W = 38;
    localparam int ADDR_W = 11;

    localparam int B_ALL_ROW_MODE = 37;
    localparam int B_L0_RD_MODE   = 36;
    localparam int B_MODE         = 35;
    localparam int B_DATA_MODE    = 34;
    localparam int B_ACC          = 33;
    localparam int B_CEN_PMEM     = 32;
    localparam int B_WEN_PMEM     = 31;
    localparam int B_A_PMEM_HI    = 30;
    localparam int B_A_PMEM_LO    = 20;
    localparam int B_CEN_XMEM     = 19;
    localparam int B_WEN_XMEM     = 18;
    localparam int B_A_XMEM_HI    = 17;
    localparam int B_A_XMEM_LO    = 7;
    localparam int B_OFIFO_RD     = 6;
    localparam int B_IFIFO_WR     = 5;
    localparam int B_IFIFO_RD     = 4;
    localparam int B_L0_RD        = 3;
    localparam int B_L0_WR        = 2;
    localparam int B_EXECUTE      = 1;
    localparam int B_LOAD         = 0;

    // Both SRAMs deselected (CEN/WEN are active-low), every strobe off.
    localparam logic [INST_W-1:0] IDLE_INST = 38'h1800C0000;

    typedef enum logic [2:0] {
        IDLE,
        W_FETCH,
        W_LOAD,
        A_FETCH,
        EXEC,
        DRAIN,
        DONE
    } ws_state_e;

    typedef struct packed {
        logic              all_row_mode;
        logic              l0_rd_mode;
        logic              mode;
        logic              data_mode;
        logic              acc;
        logic              cen_pmem;
        logic              wen_pmem;
        logic [ADDR_W-1:0] a_pmem;
        logic              cen_xmem;
        logic              wen_xmem;
        logic [ADDR_W-1:0] a_xmem;
        logic              ofifo_rd;
        logic              ififo_wr;
        logic              ififo_rd;
        logic              l0_rd;
        logic              l0_wr;
        logic              execute;
        logic              load;
    } inst_ctrl_t;

endpackage

// File: rtl/ws_inst_sequencer_inst_pack.sv
// Combinational packer: places the named control fields at their positions
// in the core instruction word.
module inst_pack
    import ws_seq_pkg::*;
(
    input  inst_ctrl_t        ctrl,
    output logic [INST_W-1:0] inst
);

    // Field-by-field placement so the word layout lives only in the package.
    always_comb begin
        inst = '0;
        inst[B_ALL_ROW_MODE]            = ctrl.all_row_mode;
        inst[B_L0_RD_MODE]              = ctrl.l0_rd_mode;
        inst[B_MODE]                    = ctrl.mode;
        inst[B_DATA_MODE]               = ctrl.data_mode;
        inst[B_ACC]                     = ctrl.acc;
        inst[B_CEN_PMEM]                = ctrl.cen_pmem;
        inst[B_WEN_PMEM]                = ctrl.wen_pmem;
        inst[B_A_PMEM_HI:B_A_PMEM_LO]   = ctrl.a_pmem;
        inst[B_CEN_XMEM]                = ctrl.cen_xmem;
        inst[B_WEN_XMEM]                = ctrl.wen_xmem;
        inst[B_A_XMEM_HI:B_A_XMEM_LO]   = ctrl.a_xmem;
        inst[B_OFIFO_RD]                = ctrl.ofifo_rd;
        inst[B_IFIFO_WR]                = ctrl.ififo_wr;
        inst[B_IFIFO_RD]                = ctrl.ififo_rd;
        inst[B_L0_RD]                   = ctrl.l0_rd;
        inst[B_L0_WR]                   = ctrl.l0_wr;
        inst[B_EXECUTE]                 = ctrl.execute;
        inst[B_LOAD]                    = ctrl.load;
    end

endmodule

// File: rtl/ws_inst_sequencer.sv
// Weight-stationary instruction sequencer. For each kernel position it walks
// weight fetch, weight load, activation fetch, execute and OFIFO drain, and
// drives the core instruction word for each cycle.
//
// OFIFO handshake: ofifo_valid means core holds a complete output row;
// ofifo_rd (inst bit 6) is the combinational accept. A word transfers in any
// cycle where both are high; ofifo_rd never rises outside DRAIN or once the
// kernel's LEN_ACT words have been taken.
module ws_inst_sequencer
    import ws_seq_pkg::*;
#(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int KIJ     = 9,
    parameter int LEN_ACT = 36,
    parameter int W_BASE  = 0,
    parameter int A_BASE  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic [3:0]        kij_idx,
    output ws_state_e         state_dbg
);

    localparam int CNT_W = $clog2(LEN_ACT + row + col + 1);
    localparam int DRN_W = $clog2(LEN_ACT + 1);

    localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(col);
    localparam logic [CNT_W-1:0] L_LAST  = CNT_W'(row + col - 1);
    localparam logic [CNT_W-1:0] A_LAST  = CNT_W'(LEN_ACT);
    localparam logic [CNT_W-1:0] E_LAST  = CNT_W'(LEN_ACT + row + col - 1);
    localparam logic [DRN_W-1:0] DRN_LEN = DRN_W'(LEN_ACT);
    localparam logic [3:0]       KIJ_LAST = 4'(KIJ - 1);

    if ((W_BASE + KIJ * col > 2048) || (KIJ > 16) || (KIJ < 1)) begin : g_cfg_check
        $error("ws_inst_sequencer: weight blocks exceed the 11-bit address space or KIJ out of range");
    end

    ws_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic [3:0]        kij_q, kij_d;
    logic [INST_W-1:0] inst_q, inst_word;
    inst_ctrl_t        ctrl;
    logic              ofifo_rd;

    // OFIFO read strobe: follows ofifo_valid in the same cycle, capped at LEN_ACT.
    always_comb begin
        ofifo_rd = (state_q == DRAIN) && ofifo_valid && (drain_q < DRN_LEN);
    end

    // Next-state, phase counter, drain counter and kernel index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        drain_d = drain_q;
        kij_d   = kij_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) state_d = W_FETCH;
            end
            W_FETCH: if (cnt_q == W_LAST) begin state_d = W_LOAD;  cnt_d = '0; end
            W_LOAD:  if (cnt_q == L_LAST) begin state_d = A_FETCH; cnt_d = '0; end
            A_FETCH: if (cnt_q == A_LAST) begin state_d = EXEC;    cnt_d = '0; end
            EXEC: begin
                if (cnt_q == E_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                cnt_d = '0;
                if (ofifo_rd) drain_d = drain_q + 1'b1;
                if (drain_q == DRN_LEN) begin
                    drain_d = '0;
                    if (kij_q == KIJ_LAST) begin
                        state_d = DONE;
                    end else begin
                        kij_d   = kij_q + 4'd1;
                        state_d = W_FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                kij_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                drain_d = '0;
                kij_d   = '0;
            end
        endcase
    end

    // Control fields for the cycle being entered, so the registered word lines up with state.
    always_comb begin
        ctrl          = '0;
        ctrl.cen_pmem = 1'b1;
        ctrl.wen_pmem = 1'b1;
        ctrl.cen_xmem = 1'b1;
        ctrl.wen_xmem = 1'b1;
        ctrl.mode     = (state_d != IDLE);
        ctrl.acc      = (kij_d != 4'd0);
        case (state_d)
            W_FETCH: begin
                ctrl.data_mode = 1'b1;
                if (cnt_d < W_LAST) begin
                    ctrl.cen_pmem = 1'b0;
                    ctrl.a_pmem   = ADDR_W'(W_BASE) + ADDR_W'(kij_d) * ADDR_W'(col) + ADDR_W'(cnt_d);
                end
                // SRAM read data arrives one cycle after the address.
                ctrl.l0_wr = (cnt_d != '0);
            end
            W_LOAD: begin
                ctrl.l0_rd        = 1'b1;
                ctrl.load         = 1'b1;
                ctrl.all_row_mode = 1'b1;
            end
            A_FETCH: begin
                if (cnt_d < A_LAST) begin
                    ctrl.cen_xmem = 1'b0;
                    ctrl.a_xmem   = ADDR_W'(A_BASE) + ADDR_W'(cnt_d);
                end
                ctrl.l0_wr = (cnt_d != '0);
            end
            EXEC: begin
                ctrl.l0_rd      = 1'b1;
                ctrl.l0_rd_mode = 1'b1;
                ctrl.execute    = 1'b1;
            end
            default: ;
        endcase
    end

    inst_pack u_inst_pack (
        .ctrl (ctrl),
        .inst (inst_word)
    );

    // State, counters and the registered instruction word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drain_q <= '0;
            kij_q   <= '0;
            inst_q  <= IDLE_INST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            kij_q   <= kij_d;
            inst_q  <= inst_word;
        end
    end

    // Splice the combinational OFIFO read into the registered word.
    always_comb begin
        inst = inst_q | (INST_W'(ofifo_rd) << B_OFIFO_RD);
    end

    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign kij_idx   = kij_q;
    assign state_dbg = state_q;

endmodule
